// File: rtl/vlsu_txn_sequencer_if.sv
// Request and transaction channels of the VLSU transaction sequencer.
// The sequencer takes the slave view; the request/bus side takes the master view.
interface vlsu_txn_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_mode;
  logic [ADDR_W-1:0] req_base;
  logic [ADDR_W-1:0] req_seg_stride;
  logic [ADDR_W-1:0] req_grp_stride;
  logic [CNT_W-1:0]  req_grp_num;
  logic [CNT_W-1:0]  req_seg_num;
  logic [CNT_W-1:0]  req_txn_num;
  logic              txn_valid;
  logic              txn_ready;
  logic [ADDR_W-1:0] txn_addr;
  logic [3:0]        txn_mode;
  logic              txn_last;
  logic              txn_seg_last;
  logic              txn_final;

  modport master (
    output req_valid, req_mode, req_base, req_seg_stride, req_grp_stride,
           req_grp_num, req_seg_num, req_txn_num, txn_ready,
    input  req_ready, txn_valid, txn_addr, txn_mode, txn_last, txn_seg_last, txn_final
  );

  modport slave (
    input  req_valid, req_mode, req_base, req_seg_stride, req_grp_stride,
           req_grp_num, req_seg_num, req_txn_num, txn_ready,
    output req_ready, txn_valid, txn_addr, txn_mode, txn_last, txn_seg_last, txn_final
  );
endinterface

// File: rtl/vlsu_txn_sequencer.sv
// Walks one VLSU request through its group/segment/transaction loops and
// issues one bus-transaction address per handshake.
module vlsu_txn_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TXN_BYTES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  vlsu_txn_sequencer_if.slave        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [ADDR_W-1:0] TxnInc = ADDR_W'(TXN_BYTES);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [3:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  txn_num_q, txn_num_d;
  logic [CNT_W-1:0]  txn_cnt_q, txn_cnt_d;
  logic [CNT_W-1:0]  rmn_seg_q, rmn_seg_d;
  logic [CNT_W-1:0]  rmn_grp_q, rmn_grp_d;
  logic [CNT_W-1:0]  seg_num_q, seg_num_d;
  logic [ADDR_W-1:0] grp_base_q, grp_base_d;
  logic [ADDR_W-1:0] seg_base_q, seg_base_d;
  logic [ADDR_W-1:0] txn_addr_q, txn_addr_d;
  logic [ADDR_W-1:0] seg_stride_q, seg_stride_d;
  logic [ADDR_W-1:0] grp_stride_q, grp_stride_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic mode_legal;
  logic is_last, is_seg_last, is_final;
  logic [CNT_W-1:0] seg_load;
  logic [ADDR_W-1:0] seg_next, grp_next;

  assign mode_legal = (bus.req_mode != 4'b0) && ((bus.req_mode & (bus.req_mode - 4'd1)) == 4'b0);
  // incr collapses to a single segment, so its segment reload is zero
  assign seg_load   = bus.req_mode[0] ? '0 : bus.req_seg_num;

  assign is_last     = (state_q == StRun) && (txn_cnt_q == txn_num_q);
  assign is_seg_last = is_last && (rmn_seg_q == '0);
  assign is_final    = is_seg_last && (rmn_grp_q == '0);
  assign seg_next    = seg_base_q + seg_stride_q;
  assign grp_next    = grp_base_q + grp_stride_q;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    txn_num_d    = txn_num_q;
    txn_cnt_d    = txn_cnt_q;
    rmn_seg_d    = rmn_seg_q;
    rmn_grp_d    = rmn_grp_q;
    seg_num_d    = seg_num_q;
    grp_base_d   = grp_base_q;
    seg_base_d   = seg_base_q;
    txn_addr_d   = txn_addr_q;
    seg_stride_d = seg_stride_q;
    grp_stride_d = grp_stride_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (mode_legal) begin
            state_d      = StRun;
            mode_d       = bus.req_mode;
            txn_num_d    = bus.req_mode[3] ? '0 : bus.req_txn_num;
            txn_cnt_d    = '0;
            seg_num_d    = seg_load;
            rmn_seg_d    = seg_load;
            rmn_grp_d    = (bus.req_mode[0] || bus.req_mode[1]) ? '0 : bus.req_grp_num;
            grp_base_d   = bus.req_base;
            seg_base_d   = bus.req_base;
            txn_addr_d   = bus.req_base;
            seg_stride_d = bus.req_seg_stride;
            grp_stride_d = bus.req_grp_stride;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        // flush wins over a same-cycle fire; counters are simply abandoned
        if (flush) begin
          state_d = StIdle;
        end else if (bus.txn_ready) begin
          if (is_final) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else if (!is_last) begin
            txn_addr_d = txn_addr_q + TxnInc;
            txn_cnt_d  = txn_cnt_q + CNT_W'(1);
          end else if (!is_seg_last) begin
            rmn_seg_d  = rmn_seg_q - CNT_W'(1);
            txn_cnt_d  = '0;
            seg_base_d = seg_next;
            txn_addr_d = seg_next;
          end else begin
            rmn_grp_d  = rmn_grp_q - CNT_W'(1);
            rmn_seg_d  = seg_num_q;
            txn_cnt_d  = '0;
            grp_base_d = grp_next;
            seg_base_d = grp_next;
            txn_addr_d = grp_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      txn_num_q    <= '0;
      txn_cnt_q    <= '0;
      rmn_seg_q    <= '0;
      rmn_grp_q    <= '0;
      seg_num_q    <= '0;
      grp_base_q   <= '0;
      seg_base_q   <= '0;
      txn_addr_q   <= '0;
      seg_stride_q <= '0;
      grp_stride_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      txn_num_q    <= txn_num_d;
      txn_cnt_q    <= txn_cnt_d;
      rmn_seg_q    <= rmn_seg_d;
      rmn_grp_q    <= rmn_grp_d;
      seg_num_q    <= seg_num_d;
      grp_base_q   <= grp_base_d;
      seg_base_q   <= seg_base_d;
      txn_addr_q   <= txn_addr_d;
      seg_stride_q <= seg_stride_d;
      grp_stride_q <= grp_stride_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.txn_valid    = (state_q == StRun);
  assign bus.txn_addr     = txn_addr_q;
  assign bus.txn_mode     = mode_q;
  assign bus.txn_last     = is_last;
  assign bus.txn_seg_last = is_seg_last;
  assign bus.txn_final    = is_final;
  assign busy             = (state_q == StRun);
  assign done             = done_q;
  assign err              = err_q;

endmodule

// File: doc/vlsu_txn_sequencer.md
# vlsu_txn_sequencer

Walks one VLSU memory request through its group, segment and transaction loops and issues one bus-transaction address per handshake. It sits between the VLSU request queue and the bus request channel, upstream of the ReqFragmenter datapath. It consumes the same meta fields that datapath tracks: rmnGrp, rmnSeg, txnCnt/txnNum, and the one-hot mode. It is the sole owner of these loop counters for the request in flight.

## Interface
- ADDR_W, 32, address and stride width
- CNT_W, 8, width of group/segment/transaction counts
- TXN_BYTES, 64, bytes covered by one transaction; power of two
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req_valid  input  1  request descriptor valid
- req_ready  output  1  sequencer can accept a descriptor
- req_mode  input  4  one-hot: [0] incr, [1] strided, [2] row2D, [3] cln2D
- req_base  input  ADDR_W  start byte address
- req_seg_stride  input  ADDR_W  byte distance between segment starts; ignored for incr
- req_grp_stride  input  ADDR_W  byte distance between group starts; 2D modes only
- req_grp_num  input  CNT_W  groups minus one
- req_seg_num  input  CNT_W  segments per group minus one
- req_txn_num  input  CNT_W  transactions per segment minus one
- flush  input  1  synchronous abort of the request in flight
- txn_valid  output  1  transaction valid
- txn_ready  input  1  downstream accepts transaction
- txn_addr  output  ADDR_W  transaction byte address
- txn_mode  output  4  latched req_mode
- txn_last  output  1  last transaction of its segment (txnCnt == txnNum)
- txn_seg_last  output  1  txn_last and last segment of its group (rmnSeg == 0)
- txn_final  output  1  txn_seg_last and last group (rmnGrp == 0)
- busy  output  1  state == RUN
- done  output  1  one-cycle pulse after the final transaction fires
- err  output  1  one-cycle pulse after an illegal descriptor is accepted

## Operation
- States: IDLE and RUN. Reset state is IDLE.
- req_ready = (state == IDLE). A request fires on req_valid && req_ready.
- Legality check on fire: req_mode must be one-hot.
  - Not one-hot: the descriptor is consumed, err pulses the next cycle, state stays IDLE, and no transactions are issued.
- Load on legal fire:
  - txnNum = req_txn_num, txnCnt = 0.
  - rmnSeg = req_seg_num, rmnGrp = req_grp_num.
  - grpBase = segBase = txnAddr = req_base.
  - State goes to RUN.
- Mode forcing at load:
  - incr: rmnSeg = rmnGrp = 0 (one contiguous segment).
  - strided: rmnGrp = 0.
  - cln2D: txnNum = 0 (one transaction per column element).
  - row2D: loaded as given.
- Advance on each txn fire (txn_valid && txn_ready), evaluated in this priority order:
  1. txn_final: state goes to IDLE, done pulses the next cycle.
  2. Not txn_last: txnAddr += TXN_BYTES, txnCnt++.
  3. txn_last, not seg_last: rmnSeg--, txnCnt = 0, segBase = txnAddr = segBase + seg_stride.
  4. seg_last, not final: rmnGrp--, rmnSeg = reloaded (forced) seg count, txnCnt = 0, grpBase = segBase = txnAddr = grpBase + grp_stride.
- All address arithmetic is unsigned modulo 2^ADDR_W; carries out of the top bit are dropped.
- flush in RUN: state goes to IDLE the next cycle, with no done and no further txn_valid. flush in IDLE has no effect. flush takes priority over a same-cycle txn fire; that fire counts as accepted by downstream, but the counters are discarded.

## Timing
- Reset values: req_ready 1; txn_valid, busy, done, err 0; txn_addr, txn_mode, and all last flags 0.
- All outputs are driven from registers or from the state and counter registers. There is no combinational path from txn_ready or req_valid to any output.
- First txn_valid appears the cycle after a legal request fire.
- Sustained throughput is one transaction per cycle while txn_ready is high.
- While txn_valid && !txn_ready, txn_addr, txn_mode and the last flags are held stable.
- txn_valid does not drop without a fire, except on flush or reset.
- The final fire returns the block to IDLE, so req_ready is 1 the next cycle. Back-to-back requests therefore have a one-cycle bubble.
- Asserting rst_n low mid-request immediately returns the block to reset values. The in-flight request is lost.

## Test plan
- Strided, base 0x1000, seg_stride 0x200, seg_num 2, txn_num 1 -> addresses 0x1000, 0x1040, 0x1200, 0x1240, 0x1400, 0x1440. txn_last on every second transaction; txn_final only on 0x1440; done pulses one cycle later.
- Row2D, base 0, seg_stride 0x100, grp_stride 0x1000, grp_num 1, seg_num 1, txn_num 0 -> 0x0, 0x100, 0x1000, 0x1100. txn_seg_last on 0x100 and 0x1100.
- Incr, base 0xFFFF_FFC0, txn_num 1, seg_num 5, grp_num 3 -> exactly two transactions, 0xFFFF_FFC0 then 0x0 (wrap); final on the second.
- Cln2D, txn_num 5, seg_num 2, seg_stride 0x8, base 0x40 -> 0x40, 0x48, 0x50, each with txn_last = 1.
- Random txn_ready back-pressure (about 50%) on the strided case -> identical address sequence, outputs held during stalls, no dropped or duplicated transaction.
- Illegal mode 4'b0011 -> err pulse, no txn_valid. Flush after 2 fires -> busy low next cycle, no done. rst_n low mid-run -> all reset values, req_ready = 1.
